stage_evaluator: RTL

- Consumes weak-classifier outputs for one detection window and accumulates them per cascade stage.
- At each stage boundary, compares the stage sum against the stage threshold supplied by the threshold ROM stage, which sits downstream of it via `stage_idx`.
- Ends the window early on the first failing stage; otherwise advances through all stages.
- Reports a face/no-face verdict plus the exit stage to the window scheduler.

---
 rtl/haar_pkg.sv | 35 +++
 rtl/sat_accumulator.sv | 40 ++++
 rtl/stage_evaluator.sv | 126 ++++++++++++
 3 files changed

// File: rtl/haar_pkg.sv
// rtl/haar_pkg.sv - Cascade constants, evaluator state type and per-stage classifier-count lookup
package haar_pkg;

  localparam int FRAC_W     = 12;
  localparam int MAX_STAGES = 22;
  localparam int CLS_CNT_W  = 8;

  localparam int STAGE_CLS_COUNT [0:MAX_STAGES-1] = '{
    9, 16, 27, 32, 52, 53, 62, 72, 83, 91, 99,
    115, 127, 135, 136, 137, 159, 155, 169, 196, 197, 181
  };

  // Q.12 images of the trained thresholds 0.822689, 6.956609, 9.498543, 18.412970, 15.324140, 21.010639,
  // 23.918791, 24.527880, 27.153351, 34.554111, 39.107288, 50.610481, 54.620071, 50.169170, 66.669120, ...
  localparam int STAGE_THRESH_Q [0:MAX_STAGES-1] = '{
    3370, 28494, 38906, 75420, 62768, 86060, 97971, 100466, 111220, 141534, 160183,
    207301, 223724, 205493, 273077, 277295, 283566, 324604, 359203, 369678, 429053, 433198
  };

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    COMPARE
  } eval_state_t;

  function automatic logic [CLS_CNT_W-1:0] stage_cls_count(input logic [4:0] idx);
    logic [CLS_CNT_W-1:0] cnt;
    cnt = '1;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (idx == 5'(i)) cnt = CLS_CNT_W'(STAGE_CLS_COUNT[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sat_accumulator.sv
// rtl/sat_accumulator.sv - Signed accumulator clamping at the ACC_W limits, with synchronous clear
module sat_accumulator #(
  parameter int VAL_W = 16,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [VAL_W-1:0] din,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  always_comb begin
    sum   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-VAL_W){din[VAL_W-1]}}, din};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      // A guard bit that disagrees with the sign bit means the true sum left the ACC_W range.
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/stage_evaluator.sv
// rtl/stage_evaluator.sv - Per-window cascade evaluation: accumulate weak values, test each stage, report verdict
module stage_evaluator
  import haar_pkg::*;
#(
  parameter int NUM_STAGES = 22,
  parameter int VAL_W      = 16,
  parameter int FRAC_W     = 12,
  parameter int ACC_W      = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    weak_valid,
  output logic                    weak_ready,
  input  logic signed [VAL_W-1:0] weak_value,
  output logic [4:0]              stage_idx,
  input  logic signed [ACC_W-1:0] stage_thresh,
  output logic                    flush,
  output logic                    result_valid,
  output logic                    face_detected,
  output logic [4:0]              exit_stage,
  output logic                    busy
);

  eval_state_t          state_q, state_d;
  logic [4:0]           stage_idx_q, stage_idx_d;
  logic [CLS_CNT_W-1:0] cls_cnt_q, cls_cnt_d;
  logic                 face_q, face_d;
  logic [4:0]           exit_q, exit_d;

  logic                    acc_clr;
  logic                    acc_en;
  logic signed [ACC_W-1:0] acc;
  logic                    stage_pass;
  logic                    last_stage;
  logic                    decide;

  sat_accumulator #(
    .VAL_W (VAL_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (weak_value),
    .acc   (acc)
  );

  // Sums and thresholds share one binary point, so a plain signed compare suffices;
  // a format without integer bits cannot hold a threshold and never passes.
  if (FRAC_W < ACC_W) begin : g_cmp
    assign stage_pass = (acc >= stage_thresh);
  end else begin : g_cmp_degenerate
    assign stage_pass = 1'b0;
  end

  assign last_stage = (stage_idx_q == 5'(NUM_STAGES - 1));
  assign decide     = (state_q == COMPARE) && (!stage_pass || last_stage);

  always_comb begin
    state_d     = state_q;
    stage_idx_d = stage_idx_q;
    cls_cnt_d   = cls_cnt_q;
    face_d      = face_q;
    exit_d      = exit_q;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_clr     = 1'b1;
          cls_cnt_d   = '0;
          stage_idx_d = '0;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        if (weak_valid) begin
          acc_en    = 1'b1;
          cls_cnt_d = cls_cnt_q + 1'b1;
          if (cls_cnt_d == stage_cls_count(stage_idx_q)) state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (decide) begin
          face_d  = stage_pass;
          exit_d  = stage_idx_q;
          state_d = IDLE;
        end else begin
          stage_idx_d = stage_idx_q + 5'd1;
          cls_cnt_d   = '0;
          acc_clr     = 1'b1;
          state_d     = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stage_idx_q <= '0;
      cls_cnt_q   <= '0;
      face_q      <= 1'b0;
      exit_q      <= '0;
    end else begin
      state_q     <= state_d;
      stage_idx_q <= stage_idx_d;
      cls_cnt_q   <= cls_cnt_d;
      face_q      <= face_d;
      exit_q      <= exit_d;
    end
  end

  // The verdict is shown during the deciding COMPARE cycle and held afterwards.
  assign result_valid  = decide;
  assign flush         = (state_q == COMPARE) && !stage_pass && !last_stage;
  assign face_detected = decide ? stage_pass : face_q;
  assign exit_stage    = decide ? stage_idx_q : exit_q;
  assign weak_ready    = (state_q == ACCUM);
  assign busy          = (state_q != IDLE);
  assign stage_idx     = stage_idx_q;

endmodule
